// File: rtl/seg7_pattern_decoder_if.sv
// Result channel of the 7-seg readback decoder: decoded value, error flag,
// valid/ready handshake and the sticky overrun flag with its clear.
interface seg7_pattern_decoder_if;
  logic [4:0] out_num;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       overrun_clr;

  modport master (
    output out_num,
    output out_err,
    output out_valid,
    output overrun,
    input  out_ready,
    input  overrun_clr
  );

  modport slave (
    input  out_num,
    input  out_err,
    input  out_valid,
    input  overrun,
    output out_ready,
    output overrun_clr
  );
endinterface

// File: rtl/seg7_pattern_decoder.sv
// Samples an active-low 7-seg bus, accepts a pattern after STABLE_CYCLES identical samples
// and decodes it into a one-entry valid/ready result buffer; a full buffer is overwritten.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [6:0]            Hex,
  seg7_pattern_decoder_if.master bus
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] RUN_SAT  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] RUN_LAST = CW'(STABLE_CYCLES - 1);

  logic [6:0]    hex_q;
  logic [CW-1:0] run_cnt;
  logic          same;
  logic          commit;
  logic [4:0]    dec_num;
  logic          dec_err;

  assign same   = (Hex == hex_q);
  // Saturation at RUN_SAT keeps a held pattern from committing more than once.
  assign commit = same && (run_cnt == RUN_LAST);

  // At the commit edge Hex equals hex_q, so decoding the register is equivalent.
  always_comb begin
    dec_num = 5'd31;
    dec_err = 1'b0;
    case (hex_q)
      7'h40: dec_num = 5'd0;
      7'h79: dec_num = 5'd1;
      7'h24: dec_num = 5'd2;
      7'h30: dec_num = 5'd3;
      7'h19: dec_num = 5'd4;
      7'h12: dec_num = 5'd5;
      7'h02: dec_num = 5'd6;
      7'h78: dec_num = 5'd7;
      7'h00: dec_num = 5'd8;
      7'h10: dec_num = 5'd9;
      7'h08: dec_num = 5'd10;
      7'h03: dec_num = 5'd11;
      7'h46: dec_num = 5'd12;
      7'h21: dec_num = 5'd13;
      7'h06: dec_num = 5'd14;
      7'h0E: dec_num = 5'd15;
      7'h7F: dec_num = 5'd16;
      default: begin
        dec_num = 5'd31;
        dec_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_q         <= 7'h7F;
      run_cnt       <= '0;
      bus.out_num   <= 5'd0;
      bus.out_err   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      hex_q <= Hex;
      if (!same)
        run_cnt <= CW'(1);
      else if (run_cnt != RUN_SAT)
        run_cnt <= run_cnt + 1'b1;

      if (commit) begin
        bus.out_num   <= dec_num;
        bus.out_err   <= dec_err;
        bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      // Set has priority over a simultaneous clear.
      if (commit && bus.out_valid && !bus.out_ready)
        bus.overrun <= 1'b1;
      else if (bus.overrun_clr)
        bus.overrun <= 1'b0;
    end
  end

endmodule
